// File: rtl/mod0_2.sv
`default_nettype none
// =============================================================================
// Module   : mod0_2
// Purpose  : Third FFT stage. Two 16-lane radix-2 SDF butterfly paths (add/sub)
//            sharing one control FSM; difference outputs are rotated by -j.
// Options  : define MOD0_2_SCALE_EN to output (x+1)>>>1 instead of full precision
// Revision : 1.0 - initial release
// =============================================================================
module mod0_2 #(
    parameter int DIN_WIDTH   = 13,
    parameter int DOUT_WIDTH  = 14,
    parameter int LANES       = 16,
    parameter int DELAY       = 4,
    parameter int FRAME_BEATS = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alert_mod02,
    input  logic signed [DIN_WIDTH-1:0]  din_R_add01  [LANES],
    input  logic signed [DIN_WIDTH-1:0]  din_Q_add01  [LANES],
    input  logic signed [DIN_WIDTH-1:0]  din_R_sub01  [LANES],
    input  logic signed [DIN_WIDTH-1:0]  din_Q_sub01  [LANES],
    output logic signed [DOUT_WIDTH-1:0] dout_R_add02 [LANES],
    output logic signed [DOUT_WIDTH-1:0] dout_Q_add02 [LANES],
    output logic signed [DOUT_WIDTH-1:0] dout_R_sub02 [LANES],
    output logic signed [DOUT_WIDTH-1:0] dout_Q_sub02 [LANES],
    output logic                         dout_valid,
    output logic                         alert_mod03,
    output logic                         overlap_err
);

    localparam int c_BEAT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam int c_PH_W   = $clog2(2 * DELAY);
    localparam int c_FL_W   = (DELAY > 1) ? $clog2(DELAY) : 1;

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(FRAME_BEATS - 1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_ONE  = c_BEAT_W'(1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_DLY  = c_BEAT_W'(DELAY);
    localparam logic [c_PH_W-1:0]   c_PH_LAST   = c_PH_W'(2 * DELAY - 1);
    localparam logic [c_PH_W-1:0]   c_PH_ONE    = c_PH_W'(1);
    localparam logic [c_PH_W-1:0]   c_PH_DLY    = c_PH_W'(DELAY);
    localparam logic [c_FL_W-1:0]   c_FL_LAST   = c_FL_W'(DELAY - 1);
    localparam logic [c_FL_W-1:0]   c_FL_ONE    = c_FL_W'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;

    logic [1:0]          state_q,     state_d;
    logic [c_BEAT_W-1:0] beat_cnt_q,  beat_cnt_d;
    logic [c_PH_W-1:0]   phase_q,     phase_d;
    logic [c_FL_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic                seam_q,      seam_d;
    logic                ovl_err_q,   ovl_err_d;
    logic                valid_q;
    logic                first_q;

    logic w_accept;
    logic w_step;
    logic w_use_din;
    logic w_fill;
    logic w_beat_valid;
    logic w_beat_first;

    // State register and control counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= c_IDLE;
            beat_cnt_q  <= '0;
            phase_q     <= '0;
            flush_cnt_q <= '0;
            seam_q      <= 1'b0;
            ovl_err_q   <= 1'b0;
            valid_q     <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            phase_q     <= phase_d;
            flush_cnt_q <= flush_cnt_d;
            seam_q      <= seam_d;
            ovl_err_q   <= ovl_err_d;
            valid_q     <= w_beat_valid;
            first_q     <= w_beat_first;
        end
    end

    // Next-state logic; an accepted alert is itself beat 0, so RUN starts at beat 1
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        phase_d     = phase_q;
        flush_cnt_d = flush_cnt_q;
        seam_d      = seam_q;
        ovl_err_d   = ovl_err_q | (alert_mod02 & ~w_accept);
        if (w_accept) begin
            state_d    = c_RUN;
            beat_cnt_d = c_BEAT_ONE;
            phase_d    = c_PH_ONE;
            seam_d     = (state_q == c_FLUSH);
        end else begin
            case (state_q)
                c_RUN: begin
                    phase_d = (phase_q == c_PH_LAST) ? '0 : phase_q + c_PH_ONE;
                    if (beat_cnt_q == c_LAST_BEAT) begin
                        state_d     = c_FLUSH;
                        beat_cnt_d  = '0;
                        flush_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + c_BEAT_ONE;
                    end
                end
                c_FLUSH: begin
                    if (flush_cnt_q == c_FL_LAST) begin
                        state_d = c_IDLE;
                    end else begin
                        flush_cnt_d = flush_cnt_q + c_FL_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control outputs; flush beats are always fill phase since FRAME_BEATS % (2*DELAY) == 0
    always_comb begin
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_use_din    = 1'b0;
        w_fill       = 1'b1;
        w_beat_valid = 1'b0;
        w_beat_first = 1'b0;
        case (state_q)
            c_IDLE: begin
                w_accept  = alert_mod02;
                w_step    = alert_mod02;
                w_use_din = alert_mod02;
            end
            c_RUN: begin
                w_step       = 1'b1;
                w_use_din    = 1'b1;
                w_fill       = (phase_q < c_PH_DLY);
                w_beat_valid = (beat_cnt_q >= c_BEAT_DLY) | seam_q;
                w_beat_first = (beat_cnt_q == c_BEAT_DLY);
            end
            c_FLUSH: begin
                w_accept     = alert_mod02 & (flush_cnt_q == '0);
                w_step       = 1'b1;
                w_use_din    = w_accept;
                w_beat_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign dout_valid  = valid_q;
    assign alert_mod03 = first_q;
    assign overlap_err = ovl_err_q;

    for (genvar p = 0; p < 2; p++) begin : g_path
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic signed [DIN_WIDTH-1:0]  w_in_r, w_in_q;
            logic signed [DOUT_WIDTH-1:0] w_x_r, w_x_q, w_f_r, w_f_q;
            logic signed [DOUT_WIDTH-1:0] w_y_r, w_y_q, w_o_r, w_o_q;
            logic signed [DOUT_WIDTH-1:0] w_push_r, w_push_q;
            logic signed [DOUT_WIDTH-1:0] dl_r_q [DELAY];
            logic signed [DOUT_WIDTH-1:0] dl_q_q [DELAY];
            logic signed [DOUT_WIDTH-1:0] out_r_q, out_q_q;

            if (p == 0) begin : g_add
                assign w_in_r          = din_R_add01[l];
                assign w_in_q          = din_Q_add01[l];
                assign dout_R_add02[l] = out_r_q;
                assign dout_Q_add02[l] = out_q_q;
            end else begin : g_sub
                assign w_in_r          = din_R_sub01[l];
                assign w_in_q          = din_Q_sub01[l];
                assign dout_R_sub02[l] = out_r_q;
                assign dout_Q_sub02[l] = out_q_q;
            end

            assign w_x_r = w_use_din ? {{(DOUT_WIDTH-DIN_WIDTH){w_in_r[DIN_WIDTH-1]}}, w_in_r} : '0;
            assign w_x_q = w_use_din ? {{(DOUT_WIDTH-DIN_WIDTH){w_in_q[DIN_WIDTH-1]}}, w_in_q} : '0;
            assign w_f_r = dl_r_q[0];
            assign w_f_q = dl_q_q[0];

            // Fill emits the stored difference rotated by -j; butterfly emits the sum
            assign w_y_r    = w_fill ? w_f_q    : w_f_r + w_x_r;
            assign w_y_q    = w_fill ? -w_f_r   : w_f_q + w_x_q;
            assign w_push_r = w_fill ? w_x_r    : w_f_r - w_x_r;
            assign w_push_q = w_fill ? w_x_q    : w_f_q - w_x_q;

`ifdef MOD0_2_SCALE_EN
            logic signed [DOUT_WIDTH:0] w_rnd_r, w_rnd_q;
            assign w_rnd_r = {w_y_r[DOUT_WIDTH-1], w_y_r} + (DOUT_WIDTH+1)'(1);
            assign w_rnd_q = {w_y_q[DOUT_WIDTH-1], w_y_q} + (DOUT_WIDTH+1)'(1);
            assign w_o_r   = w_rnd_r[DOUT_WIDTH:1];
            assign w_o_q   = w_rnd_q[DOUT_WIDTH:1];
`else
            assign w_o_r = w_y_r;
            assign w_o_q = w_y_q;
`endif

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DELAY; i++) begin
                        dl_r_q[i] <= '0;
                        dl_q_q[i] <= '0;
                    end
                end else if (w_step) begin
                    for (int i = 0; i < DELAY - 1; i++) begin
                        dl_r_q[i] <= dl_r_q[i+1];
                        dl_q_q[i] <= dl_q_q[i+1];
                    end
                    dl_r_q[DELAY-1] <= w_push_r;
                    dl_q_q[DELAY-1] <= w_push_q;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_r_q <= '0;
                    out_q_q <= '0;
                end else begin
                    out_r_q <= w_beat_valid ? w_o_r : '0;
                    out_q_q <= w_beat_valid ? w_o_q : '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mod0_2.sv
`default_nettype none
// =============================================================================
// Module   : tb_mod0_2
// Purpose  : Directed, table-driven self-checking bench for mod0_2.
// Revision : 1.0 - initial release
// =============================================================================
module tb_mod0_2;

    localparam int DW = 13;
    localparam int OW = 14;
    localparam int L  = 16;
    localparam int FB = 32;

    logic clk = 1'b0;
    logic rst;
    logic alert_mod02;
    logic signed [DW-1:0] din_R_add01 [L];
    logic signed [DW-1:0] din_Q_add01 [L];
    logic signed [DW-1:0] din_R_sub01 [L];
    logic signed [DW-1:0] din_Q_sub01 [L];
    logic signed [OW-1:0] dout_R_add02 [L];
    logic signed [OW-1:0] dout_Q_add02 [L];
    logic signed [OW-1:0] dout_R_sub02 [L];
    logic signed [OW-1:0] dout_Q_sub02 [L];
    logic dout_valid;
    logic alert_mod03;
    logic overlap_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mod0_2 dut (
        .clk          (clk),
        .rst          (rst),
        .alert_mod02  (alert_mod02),
        .din_R_add01  (din_R_add01),
        .din_Q_add01  (din_Q_add01),
        .din_R_sub01  (din_R_sub01),
        .din_Q_sub01  (din_Q_sub01),
        .dout_R_add02 (dout_R_add02),
        .dout_Q_add02 (dout_Q_add02),
        .dout_R_sub02 (dout_R_sub02),
        .dout_Q_sub02 (dout_Q_sub02),
        .dout_valid   (dout_valid),
        .alert_mod03  (alert_mod03),
        .overlap_err  (overlap_err)
    );

    typedef struct {
        int id;
        int n;
        int path;
        int lane;
        int r;
        int q;
        int v;
        int a;
    } vec_t;

    vec_t vecs[$];

    // Expected output value as seen at the port (scaled when the option is built in)
    function automatic int sc(input int x);
`ifdef MOD0_2_SCALE_EN
        return (x + 1) >>> 1;
`else
        return x;
`endif
    endfunction

    function automatic int out_r(input int path, input int lane);
        return (path == 0) ? int'(dout_R_add02[lane]) : int'(dout_R_sub02[lane]);
    endfunction

    function automatic int out_q(input int path, input int lane);
        return (path == 0) ? int'(dout_Q_add02[lane]) : int'(dout_Q_sub02[lane]);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input int id, input int n, input int path, input int lane,
                           input int r, input int q, input int v, input int a);
        vec_t e;
        e.id = id; e.n = n; e.path = path; e.lane = lane;
        e.r = r; e.q = q; e.v = v; e.a = a;
        vecs.push_back(e);
    endtask

    task automatic clear_inputs();
        for (int l = 0; l < L; l++) begin
            din_R_add01[l] = '0; din_Q_add01[l] = '0;
            din_R_sub01[l] = '0; din_Q_sub01[l] = '0;
        end
    endtask

    // kind 0: constant R=100 on all add lanes; 1: impulse; 2: sub-lane-3 extremes
    task automatic drive_beat(input int kind, input int k, input int nframes);
        clear_inputs();
        case (kind)
            0: if (k < FB * nframes) for (int l = 0; l < L; l++) din_R_add01[l] = DW'(100);
            1: if (k == 0) din_R_add01[0] = DW'(1000);
            2: begin
                if (k == 0) din_R_sub01[3] = DW'(-4096);
                if (k == 4) din_R_sub01[3] = DW'(4095);
            end
            default: ;
        endcase
    endtask

    task automatic all_zero_check(input string tag);
        int nz;
        nz = 0;
        for (int l = 0; l < L; l++) begin
            if (dout_R_add02[l] != 0 || dout_Q_add02[l] != 0 ||
                dout_R_sub02[l] != 0 || dout_Q_sub02[l] != 0) nz++;
        end
        check({tag, "_nonzero_lanes"}, nz, 0);
        check({tag, "_valid"}, int'(dout_valid), 0);
        check({tag, "_alert03"}, int'(alert_mod03), 0);
        check({tag, "_ovl"}, int'(overlap_err), 0);
    endtask

    // Runs one stimulus stream; alert2 >= 0 raises a second alert at that cycle
    task automatic run(input int id, input int kind, input int alert2, input int nframes,
                       input int ncyc, input int exp_vcnt, input int exp_vlast,
                       input int exp_acnt, input int exp_a2, input int exp_ovl);
        int vcnt, vfirst, vlast, acnt, a1, a2;
        vcnt = 0; vfirst = -1; vlast = -1; acnt = 0; a1 = -1; a2 = -1;
        drive_beat(kind, 0, nframes);
        alert_mod02 = 1'b1;
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk); #1;
            drive_beat(kind, n, nframes);
            alert_mod02 = (n == alert2);
            if (dout_valid) begin
                vcnt++;
                if (vfirst < 0) vfirst = n;
                vlast = n;
            end
            if (alert_mod03) begin
                acnt++;
                if (a1 < 0) a1 = n; else a2 = n;
            end
            foreach (vecs[i]) begin
                if (vecs[i].id == id && vecs[i].n == n) begin
                    check($sformatf("t%0d_n%0d_p%0d_l%0d_R", id, n, vecs[i].path, vecs[i].lane),
                          out_r(vecs[i].path, vecs[i].lane), sc(vecs[i].r));
                    check($sformatf("t%0d_n%0d_p%0d_l%0d_Q", id, n, vecs[i].path, vecs[i].lane),
                          out_q(vecs[i].path, vecs[i].lane), sc(vecs[i].q));
                    check($sformatf("t%0d_n%0d_valid", id, n), int'(dout_valid), vecs[i].v);
                    check($sformatf("t%0d_n%0d_alert03", id, n), int'(alert_mod03), vecs[i].a);
                end
            end
        end
        clear_inputs();
        alert_mod02 = 1'b0;
        check($sformatf("t%0d_valid_count", id), vcnt, exp_vcnt);
        check($sformatf("t%0d_valid_first", id), vfirst, 5);
        check($sformatf("t%0d_valid_last", id), vlast, exp_vlast);
        check($sformatf("t%0d_alert03_count", id), acnt, exp_acnt);
        check($sformatf("t%0d_alert03_first", id), a1, 5);
        check($sformatf("t%0d_alert03_second", id), a2, exp_a2);
        check($sformatf("t%0d_overlap_err", id), int'(overlap_err), exp_ovl);
    endtask

    initial begin
        // id, cycle offset, path, lane, expected R, expected Q, dout_valid, alert_mod03
        add_vec(0,  4, 0,  0,    0,     0, 0, 0);
        add_vec(0,  5, 0,  0,  200,     0, 1, 1);
        add_vec(0,  5, 0, 15,  200,     0, 1, 1);
        add_vec(0,  5, 1,  0,    0,     0, 1, 1);
        add_vec(0,  8, 0,  7,  200,     0, 1, 0);
        add_vec(0,  9, 0,  0,    0,     0, 1, 0);
        add_vec(0, 13, 0,  0,  200,     0, 1, 0);
        add_vec(0, 32, 0,  0,  200,     0, 1, 0);
        add_vec(0, 33, 0,  0,    0,     0, 1, 0);
        add_vec(0, 36, 0,  0,    0,     0, 1, 0);
        add_vec(0, 37, 0,  0,    0,     0, 0, 0);
        add_vec(1,  5, 0,  0, 1000,     0, 1, 1);
        add_vec(1,  5, 0,  1,    0,     0, 1, 1);
        add_vec(1,  9, 0,  0,    0, -1000, 1, 0);
        add_vec(1,  9, 1,  0,    0,     0, 1, 0);
        add_vec(1, 13, 0,  0,    0,     0, 1, 0);
        add_vec(2,  5, 1,  3,   -1,     0, 1, 1);
        add_vec(2,  5, 0,  3,    0,     0, 1, 1);
        add_vec(2,  9, 1,  3,    0,  8191, 1, 0);
        add_vec(2, 13, 1,  3,    0,     0, 1, 0);
        add_vec(3,  5, 0,  0,  200,     0, 1, 1);
        add_vec(3, 12, 0,  0,    0,     0, 1, 0);
        add_vec(3, 13, 0,  0,  200,     0, 1, 0);
        add_vec(4, 33, 0,  0,    0,     0, 1, 0);
        add_vec(4, 36, 0,  0,    0,     0, 1, 0);
        add_vec(4, 37, 0,  0,  200,     0, 1, 1);
        add_vec(4, 41, 0,  0,    0,     0, 1, 0);
        add_vec(4, 64, 0,  0,  200,     0, 1, 0);
        add_vec(4, 68, 0,  0,    0,     0, 1, 0);
        add_vec(4, 69, 0,  0,    0,     0, 0, 0);

        rst = 1'b1;
        alert_mod02 = 1'b0;
        clear_inputs();
        #2;
        all_zero_check("reset_initial");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run(0, 0, -1, 1, 40, 32, 36, 1, -1, 0);
        repeat (2) @(posedge clk); #1;
        run(1, 1, -1, 1, 40, 32, 36, 1, -1, 0);
        repeat (2) @(posedge clk); #1;
        run(2, 2, -1, 1, 40, 32, 36, 1, -1, 0);
        repeat (2) @(posedge clk); #1;
        run(3, 0, 10, 1, 40, 32, 36, 1, -1, 1);

        // Mid-idle reset clears the sticky error without waiting for a clock edge
        #2 rst = 1'b1;
        #1 all_zero_check("reset_idle");
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;

        // Mid-frame reset: outputs are live, then drop to zero asynchronously
        drive_beat(0, 0, 1);
        alert_mod02 = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk); #1;
            alert_mod02 = 1'b0;
            drive_beat(0, n, 1);
        end
        check("midframe_pre_R", int'(dout_R_add02[0]), sc(200));
        check("midframe_pre_valid", int'(dout_valid), 1);
        #2 rst = 1'b1;
        #1 all_zero_check("reset_midframe");
        clear_inputs();
        @(posedge clk); #3 rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        run(0, 0, -1, 1, 40, 32, 36, 1, -1, 0);
        repeat (2) @(posedge clk); #1;
        run(4, 0, 32, 2, 72, 64, 68, 2, 37, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
